// File: rtl/uart_rx_if.sv
// Byte-stream handshake plus error strobes between uart_rx and its consumer.
// The master side is the receiver; the slave side is the consumer.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start-glitch rejection, framing/overrun strobes
// and a one-entry valid/ready holding register.
module uart_rx #(
    parameter int CLKS_PER_BIT = 12
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx,
    uart_rx_if.master bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          sync1, rxs;
    logic          deliver;
    logic          ferr_d;
    logic          ovr_d;
    logic          load;
    logic          accept;

    // Two-flop synchronizer; idle-high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    sh_d  = {rxs, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A consume in the deliver cycle frees the slot for the new byte
    assign accept = bus.valid && bus.ready;
    assign ovr_d  = deliver && bus.valid && !bus.ready;
    assign load   = deliver && !ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data      <= 8'h00;
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.frame_err <= ferr_d;
            bus.overrun   <= ovr_d;
            if (load) begin
                bus.data  <= sh_q;
                bus.valid <= 1'b1;
            end else if (accept) begin
                bus.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames in, scoreboard of expected
// bytes popped on every valid&&ready handshake.
`timescale 1ns/1ps
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int ov0;
    logic [7:0] q[$];

    uart_rx_if bus();

    uart_rx #(.CLKS_PER_BIT(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(12);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(12);
        end
        rx = stop;
        tick(12);
        rx = 1'b1;
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (q.size() != 0 && n < lim) begin
            tick(1);
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"}, bus.data, 8'h00);
        check({tag, "_valid"}, bus.valid, 1'b0);
        check({tag, "_ferr"}, bus.frame_err, 1'b0);
        check({tag, "_ovr"}, bus.overrun, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_err) fe_cnt++;
            if (bus.overrun) ov_cnt++;
            if (bus.valid && bus.ready) begin
                if (q.size() == 0)
                    check("unexpected_byte", q.size(), 1);
                else
                    check("rx_byte", bus.data, q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] b3c;
        rst_n = 1'b0;
        rx = 1'b1;
        bus.ready = 1'b1;
        tick(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick(5);

        // basic receive with exact latency
        q.push_back(8'h31);
        fork
            send(8'h31, 1'b1);
            begin
                tick(116);
                check("lat_pre_valid", bus.valid, 1'b0);
                tick(1);
                check("lat_valid", bus.valid, 1'b1);
                check("lat_data", bus.data, 8'h31);
                tick(1);
                check("lat_post_valid", bus.valid, 1'b0);
            end
        join
        tick(10);
        check("basic_ferr", fe_cnt, 0);
        check("basic_ovr", ov_cnt, 0);

        // start-bit glitch
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(30);
        check("glitch_ferr", fe_cnt, 0);
        check("glitch_valid", bus.valid, 1'b0);
        q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        drain(40);
        tick(5);

        // framing error followed by break
        send(8'h5A, 1'b0);
        rx = 1'b0;
        tick(600);
        rx = 1'b1;
        tick(24);
        check("ferr_count", fe_cnt, 1);
        check("ferr_no_valid", bus.valid, 1'b0);
        q.push_back(8'hC3);
        send(8'hC3, 1'b1);
        drain(40);
        check("ferr_count_after", fe_cnt, 1);

        // overrun
        bus.ready = 1'b0;
        ov0 = ov_cnt;
        q.push_back(8'h11);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        tick(10);
        check("ovr_valid", bus.valid, 1'b1);
        check("ovr_data", bus.data, 8'h11);
        check("ovr_count", ov_cnt, ov0 + 1);
        bus.ready = 1'b1;
        tick(1);
        bus.ready = 1'b0;
        tick(3);
        check("ovr_cleared", bus.valid, 1'b0);
        check("ovr_data_kept", bus.data, 8'h11);
        check("ovr_q", q.size(), 0);
        tick(20);
        check("ovr_no_22", bus.valid, 1'b0);
        bus.ready = 1'b1;

        // back-to-back, ready held high
        q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'h80);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h80, 1'b1);
        drain(20);

        // back-to-back, ready only on the deliver cycle
        bus.ready = 1'b0;
        ov0 = ov_cnt;
        q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'h80);
        fork
            begin
                send(8'h00, 1'b1);
                send(8'hFF, 1'b1);
                send(8'h80, 1'b1);
            end
            begin
                tick(236);
                bus.ready = 1'b1;
                tick(1);
                bus.ready = 1'b0;
                tick(119);
                bus.ready = 1'b1;
                tick(1);
                bus.ready = 1'b0;
            end
        join
        check("sim_valid", bus.valid, 1'b1);
        check("sim_data", bus.data, 8'h80);
        bus.ready = 1'b1;
        drain(5);
        check("sim_no_ovr", ov_cnt, ov0);

        // reset during data bit 4 of 0x3C
        b3c = 8'h3C;
        rx = 1'b0;
        tick(12);
        for (int i = 0; i < 4; i++) begin
            rx = b3c[i];
            tick(12);
        end
        rx = b3c[4];
        tick(6);
        rst_n = 1'b0;
        rx = 1'b1;
        tick(1);
        check_reset_vals("midrst");
        tick(23);
        rst_n = 1'b1;
        tick(36);
        check("midrst_no_valid", bus.valid, 1'b0);
        check("midrst_q", q.size(), 0);
        q.push_back(8'h96);
        send(8'h96, 1'b1);
        drain(40);

        tick(10);
        check("final_ferr", fe_cnt, 1);
        check("final_ovr", ov_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
